// File: rtl/ram_pipe_be_if.sv
// Request/response bus between the tinyriscv interconnect and the data RAM.
// Request channel is req/gnt; the response (rvalid, rdata, err) returns after a fixed latency.
interface ram_pipe_be_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  req;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W/8-1:0]   be;
   logic [DATA_W-1:0]     wdata;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;
   logic                  err;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/ram_pipe_be.sv
// Single-port data RAM with byte-lane writes, a fixed RD_LAT response pipeline
// and error responses for misaligned or out-of-range accesses.
module ram_pipe_be #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   ram_pipe_be_if.slave bus
);
   localparam int BE_W   = DATA_W / 8;
   localparam int OFF    = $clog2(BE_W);
   localparam int IDX_W  = ADDR_W - OFF;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0]              mem_r [DEPTH];
   logic [IDX_W-1:0]               idx_s;
   logic [MEM_AW-1:0]              mem_idx_s;
   logic                           accept_s;
   logic                           misalign_s;
   logic                           range_err_s;
   logic                           err_s;
   logic                           wr_en_s;
   logic [DATA_W-1:0]              rd_data_s;
   logic [RD_LAT-1:0]              vld_r;
   logic [RD_LAT-1:0]              err_r;
   logic [RD_LAT-1:0][DATA_W-1:0]  dat_r;

   assign idx_s       = bus.addr[ADDR_W-1:OFF];
   assign misalign_s  = (bus.addr[OFF-1:0] != {OFF{1'b0}});
   // Range is checked against DEPTH itself, so a non-power-of-two DEPTH still faults.
   assign range_err_s = (64'(idx_s) >= 64'(DEPTH));
   assign err_s       = misalign_s | range_err_s;

   assign bus.gnt     = bus.req & ~rst;
   assign accept_s    = bus.req & bus.gnt;
   assign wr_en_s     = accept_s & bus.we & ~err_s;
   assign mem_idx_s   = range_err_s ? {MEM_AW{1'b0}} : idx_s[MEM_AW-1:0];

   // Read word for an accepted, error-free read; writes and errors respond with zero.
   always_comb begin
      rd_data_s = {DATA_W{1'b0}};
      if (accept_s && !bus.we && !err_s) begin
         rd_data_s = mem_r[mem_idx_s];
      end else begin
         rd_data_s = {DATA_W{1'b0}};
      end
   end

   // Byte-lane write port; the array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < BE_W; k++) begin
         if (wr_en_s && bus.be[k]) begin
            mem_r[mem_idx_s][8*k +: 8] <= bus.wdata[8*k +: 8];
         end
      end
   end

   // Response shift register; reset drops every in-flight response.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r <= {RD_LAT{1'b0}};
         err_r <= {RD_LAT{1'b0}};
         dat_r <= {(RD_LAT*DATA_W){1'b0}};
      end else begin
         vld_r[0] <= accept_s;
         err_r[0] <= accept_s & err_s;
         dat_r[0] <= rd_data_s;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_r[i] <= vld_r[i-1];
            err_r[i] <= err_r[i-1];
            dat_r[i] <= dat_r[i-1];
         end
      end
   end

   assign bus.rvalid = vld_r[RD_LAT-1];
   assign bus.err    = err_r[RD_LAT-1];
   assign bus.rdata  = dat_r[RD_LAT-1];
endmodule

// File: tb/tb_ram_pipe_be.sv
// Bench for ram_pipe_be: two instances (RD_LAT=1 and RD_LAT=3) fed identical traffic
// and checked against a word-array memory model with per-latency response queues.
module tb_ram_pipe_be;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 256;

   typedef struct {
      logic          rst;
      logic          rq;
      logic          we;
      logic [AW-1:0] a;
      logic [3:0]    be;
      logic [DW-1:0] d;
   } op_t;

   typedef struct {
      int          due;
      logic [DW:0] rsp;
   } pend_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_v;
   logic          we_v;
   logic [AW-1:0] addr_v;
   logic [3:0]    be_v;
   logic [DW-1:0] wdata_v;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [DW-1:0] mem_m [DEPTH];
   pend_t         q1[$];
   pend_t         q3[$];
   logic          v1;
   logic          v3;
   logic [DW:0]   r1;
   logic [DW:0]   r3;

   always #5 clk = ~clk;

   ram_pipe_be_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
   ram_pipe_be_if #(.DATA_W(DW), .ADDR_W(AW)) b3 ();

   assign b1.req = req_v;   assign b3.req = req_v;
   assign b1.we = we_v;     assign b3.we = we_v;
   assign b1.addr = addr_v; assign b3.addr = addr_v;
   assign b1.be = be_v;     assign b3.be = be_v;
   assign b1.wdata = wdata_v; assign b3.wdata = wdata_v;

   ram_pipe_be #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   ram_pipe_be #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RD_LAT(3)) u_lat3 (
      .clk (clk),
      .rst (rst),
      .bus (b3.slave)
   );

   function automatic op_t mk(input logic r, input logic q, input logic w,
                              input logic [AW-1:0] a, input logic [3:0] b, input logic [DW-1:0] d);
      op_t o;
      o.rst = r; o.rq = q; o.we = w; o.a = a; o.be = b; o.d = d;
      return o;
   endfunction

   task automatic drive(input op_t o);
      rst = o.rst; req_v = o.rq; we_v = o.we; addr_v = o.a; be_v = o.be; wdata_v = o.d;
      #1;
   endtask

   // One clock edge of the reference model: apply the request, then report which
   // responses are due right after this edge (accept edge + latency - 1).
   task automatic tick();
      logic [DW:0] rsp;
      int unsigned idx;
      logic        er;
      pend_t       p;
      @(posedge clk);
      if (rst) begin
         q1.delete();
         q3.delete();
      end else if (req_v) begin
         idx = addr_v / 4;
         er  = (addr_v % 4 != 0) || (idx >= DEPTH);
         rsp = {er, 32'h0};
         if (!we_v && !er) rsp = {1'b0, mem_m[idx]};
         if (we_v && !er)
            for (int k = 0; k < 4; k++)
               if (be_v[k]) mem_m[idx][8*k +: 8] = wdata_v[8*k +: 8];
         q1.push_back('{cyc, rsp});
         q3.push_back('{cyc + 2, rsp});
      end
      v1 = 1'b0; r1 = '0; v3 = 1'b0; r3 = '0;
      if (q1.size() > 0 && q1[0].due == cyc) begin p = q1.pop_front(); v1 = 1'b1; r1 = p.rsp; end
      if (q3.size() > 0 && q3[0].due == cyc) begin p = q3.pop_front(); v3 = 1'b1; r3 = p.rsp; end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      op_t ops[$];
      ops.push_back(mk(1'b1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0));
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h14, 4'hF, 32'h1234));
      ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         n_checks++;
         if (b1.gnt !== (ops[i].rq & ~ops[i].rst) || b3.gnt !== (ops[i].rq & ~ops[i].rst)) begin
            n_fail++;
            $display("FAIL reset gnt[%0d]: got %b/%b want %b", i, b1.gnt, b3.gnt, ops[i].rq & ~ops[i].rst);
         end
         tick();
         n_checks++;
         if ({b1.rvalid, b1.err, b1.rdata, b3.rvalid, b3.err, b3.rdata} !== {2*(DW+2){1'b0}}) begin
            n_fail++;
            $display("FAIL reset outputs[%0d]: got %b %b %h / %b %b %h want all zero",
                     i, b1.rvalid, b1.err, b1.rdata, b3.rvalid, b3.err, b3.rdata);
         end
      end
   endtask

   task automatic test_preload();
      op_t ops[$];
      for (int w = 0; w < DEPTH; w++) ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'(w * 4), 4'hF, $urandom));
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         tick();
         n_checks += 2;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL preload lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL preload lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
      end
   endtask

   task automatic test_write_read();
      op_t ops[$];
      ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h11223344));
      ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'h20, 4'h5, 32'hAABBCCDD));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'h30, 4'h0, 32'hFFFFFFFF));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0));
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         n_checks++;
         if (b1.gnt !== ops[i].rq) begin
            n_fail++;
            $display("FAIL wr_rd gnt[%0d]: got %b want %b", i, b1.gnt, ops[i].rq);
         end
         tick();
         n_checks += 2;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL wr_rd lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL wr_rd lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
         if (i == 1 || i == 4 || i == 5) begin
            n_checks++;
            if ({b1.rvalid, b1.err, b1.rdata} !== {2'b10, (i == 1) ? 32'hDEADBEEF : (i == 4) ? 32'h11BB33DD : 32'h0}) begin
               n_fail++;
               $display("FAIL wr_rd known[%0d]: got %b %b %h", i, b1.rvalid, b1.err, b1.rdata);
            end
         end
      end
   endtask

   task automatic test_errors();
      op_t ops[$];
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h13, 4'hF, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'(DEPTH * 4), 4'hF, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b1, 32'h22, 4'hF, 32'h12345678));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0));
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         tick();
         n_checks += 2;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL errors lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL errors lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
         if (i <= 3) begin
            n_checks++;
            if ({b1.rvalid, b1.err, b1.rdata} !== {1'b1, (i <= 2), (i == 3) ? 32'h11BB33DD : 32'h0}) begin
               n_fail++;
               $display("FAIL errors known[%0d]: got %b %b %h", i, b1.rvalid, b1.err, b1.rdata);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      op_t ops[$];
      for (int k = 0; k < 4; k++) ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'(k * 4), 4'hF, 32'h0));
      for (int k = 0; k < 4; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         tick();
         n_checks += 3;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL b2b lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL b2b lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
         if (b3.rvalid !== (i >= 2 && i <= 5)) begin
            n_fail++;
            $display("FAIL b2b window[%0d]: got rvalid %b want %b", i, b3.rvalid, (i >= 2 && i <= 5));
         end
      end
   endtask

   task automatic test_reset_inflight();
      op_t ops[$];
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0));
      ops.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D));
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0));
      ops.push_back(mk(1'b0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0));
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         n_checks++;
         if (b1.gnt !== (ops[i].rq & ~ops[i].rst) || b3.gnt !== (ops[i].rq & ~ops[i].rst)) begin
            n_fail++;
            $display("FAIL rst_fly gnt[%0d]: got %b/%b want %b", i, b1.gnt, b3.gnt, ops[i].rq & ~ops[i].rst);
         end
         tick();
         n_checks += 2;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL rst_fly lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL rst_fly lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
      end
   endtask

   task automatic test_random();
      op_t ops[$];
      logic [AW-1:0] a;
      int unsigned kind;
      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 9);
         a = 32'($urandom_range(0, DEPTH - 1) * 4);
         if (kind == 8) a = a + 32'($urandom_range(1, 3));
         if (kind == 9) a = ($urandom | 32'h0001_0000) & 32'hFFFF_FFFC;
         ops.push_back(mk(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 8), 1'($urandom),
                          a, 4'($urandom), $urandom));
      end
      for (int k = 0; k < 3; k++) ops.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0));
      foreach (ops[i]) begin
         drive(ops[i]);
         n_checks++;
         if (b1.gnt !== (ops[i].rq & ~ops[i].rst) || b3.gnt !== (ops[i].rq & ~ops[i].rst)) begin
            n_fail++;
            $display("FAIL random gnt[%0d]: got %b/%b want %b", i, b1.gnt, b3.gnt, ops[i].rq & ~ops[i].rst);
         end
         tick();
         n_checks += 2;
         if (b1.rvalid !== v1 || (v1 && {b1.err, b1.rdata} !== r1)) begin
            n_fail++;
            $display("FAIL random lat1[%0d]: got %b %b %h want %b %b %h", i, b1.rvalid, b1.err, b1.rdata, v1, r1[DW], r1[DW-1:0]);
         end
         if (b3.rvalid !== v3 || (v3 && {b3.err, b3.rdata} !== r3)) begin
            n_fail++;
            $display("FAIL random lat3[%0d]: got %b %b %h want %b %b %h", i, b3.rvalid, b3.err, b3.rdata, v3, r3[DW], r3[DW-1:0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_write_read();
      test_errors();
      test_back_to_back();
      test_reset_inflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
